// File: rtl/ram_rmw_sched_pkg.sv
// ram_rmw_sched_pkg: shared FSM state, update op encoding and requester count
// for the read-modify-write scheduler.
package ram_rmw_sched_pkg;
    typedef enum logic [1:0] {INIT, IDLE, FETCH, MERGE} state_t;
    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;
    localparam int NUM_REQ = 2;
endpackage

// File: rtl/ram_rmw_rr_arb.sv
// ram_rmw_rr_arb: 2-way round-robin grant; the pointer only moves when both
// requesters compete, so a lone requester never loses its turn.
module ram_rmw_rr_arb
    import ram_rmw_sched_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Enable,
    input  logic [NUM_REQ-1:0] Req,
    output logic [NUM_REQ-1:0] Gnt
);
    logic ptr;

    always_comb Gnt = !Enable ? '0 : &Req ? (ptr ? 2'b10 : 2'b01) : Req;

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) ptr <= 1'b0;
        else if (Enable && &Req) ptr <= ~ptr;
endmodule

// File: rtl/ram_rmw_sched.sv
// ram_rmw_sched: serialized set/clear-mask RMW scheduler over a 1R1W RAM with a
// clear sweep after reset; RAM_RMW_SCHED_BYPASS_EN forwards merged words to colliding lookups.
module ram_rmw_sched
    import ram_rmw_sched_pkg::*;
#(
    parameter int A = 9,
    parameter int D = 64
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [NUM_REQ-1:0]   UpdValid,
    output logic [NUM_REQ-1:0]   UpdReady,
    input  logic [2*A-1:0]       UpdAddr,
    input  logic [NUM_REQ-1:0]   UpdOp,
    input  logic [2*D-1:0]       UpdMask,
    output logic [NUM_REQ-1:0]   UpdDone,
    input  logic                 LkpValid,
    input  logic [A-1:0]         LkpAddr,
    output logic                 LkpRspValid,
    output logic [D-1:0]         LkpRspData,
    output logic                 InitDone,
    output logic                 RamWrEnb,
    output logic [A-1:0]         RamWrAddr,
    output logic [D-1:0]         RamWrData,
    input  logic [D-1:0]         RamWrDataOut,
    output logic                 RamRdEnb,
    output logic [A-1:0]         RamRdAddr,
    input  logic [D-1:0]         RamRdData
);
    state_t state, nextState;
    logic [A-1:0] cnt, capAddr;
    logic capOp;
    logic [D-1:0] capMask, merged;
    logic [NUM_REQ-1:0] gnt, capGnt;

    ram_rmw_rr_arb uArb (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Enable(state == IDLE),
        .Req(UpdValid),
        .Gnt(gnt)
    );

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) state <= INIT;
        else state <= nextState;

    always_comb begin
        nextState = state;
        case (state)
            INIT:  nextState = &cnt ? IDLE : INIT;
            IDLE:  nextState = |gnt ? FETCH : IDLE;
            FETCH: nextState = MERGE;
            MERGE: nextState = IDLE;
        endcase
    end

    // RamWrDataOut holds the old word during MERGE because FETCH presented the address.
    always_comb begin
        merged    = capOp == OP_SET ? RamWrDataOut | capMask : RamWrDataOut & ~capMask;
        UpdReady  = gnt;
        RamWrEnb  = Rst_n && (state == INIT || state == MERGE);
        RamWrAddr = state == INIT ? cnt : capAddr;
        RamWrData = state == INIT ? '0 : merged;
        RamRdEnb  = LkpValid && InitDone;
        RamRdAddr = LkpAddr;
    end

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            cnt         <= '0;
            capAddr     <= '0;
            capOp       <= OP_CLR;
            capMask     <= '0;
            capGnt      <= '0;
            UpdDone     <= '0;
            InitDone    <= 1'b0;
            LkpRspValid <= 1'b0;
        end else begin
            cnt         <= state == INIT ? cnt + 1'b1 : '0;
            UpdDone     <= state == MERGE ? capGnt : '0;
            InitDone    <= state != INIT || &cnt;
            LkpRspValid <= RamRdEnb;
            if (|gnt) begin
                capAddr <= gnt[1] ? UpdAddr[2*A-1:A] : UpdAddr[A-1:0];
                capOp   <= gnt[1] ? UpdOp[1] : UpdOp[0];
                capMask <= gnt[1] ? UpdMask[2*D-1:D] : UpdMask[D-1:0];
                capGnt  <= gnt;
            end
        end

`ifdef RAM_RMW_SCHED_BYPASS_EN
    logic fwdHit;
    logic [D-1:0] fwdWord;

    // Registered select: the forwarded word replaces the read-first RAM data at no extra latency.
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            fwdHit  <= 1'b0;
            fwdWord <= '0;
        end else begin
            fwdHit  <= RamRdEnb && state == MERGE && LkpAddr == capAddr;
            fwdWord <= merged;
        end

    always_comb LkpRspData = !LkpRspValid ? '0 : fwdHit ? fwdWord : RamRdData;
`else
    always_comb LkpRspData = LkpRspValid ? RamRdData : '0;
`endif
endmodule

// File: doc/ram_rmw_sched.md
RAM_RMW_SCHED -- requirements
Module: ram_rmw_sched

Interface
REQ-001 SHALL have parameter A, default 9, meaning RAM address width in bits.
REQ-002 SHALL have parameter D, default 64, meaning RAM data width in bits.
REQ-003 SHALL have port Clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port UpdValid  in  2  update request, bit i = requester i.
REQ-006 SHALL have port UpdReady  out  2  update accepted when UpdValid[i]&UpdReady[i].
REQ-007 SHALL have port UpdAddr  in  2*A  target address, slice i for requester i.
REQ-008 SHALL have port UpdOp  in  2  1 = set mask bits, 0 = clear mask bits.
REQ-009 SHALL have port UpdMask  in  2*D  bit mask, slice i for requester i.
REQ-010 SHALL have port UpdDone  out  2  one-cycle pulse, update i committed.
REQ-011 SHALL have port LkpValid  in  1  lookup request, always accepted when InitDone=1.
REQ-012 SHALL have port LkpAddr  in  A  lookup address.
REQ-013 SHALL have port LkpRspValid  out  1  lookup response valid.
REQ-014 SHALL have port LkpRspData  out  D  lookup response word.
REQ-015 SHALL have port InitDone  out  1  high once the clear sweep has finished.
REQ-016 SHALL have ports RamWrEnb out 1, RamWrAddr out A, RamWrData out D, RamWrDataOut in D: write port of a 1R1W read-first RAM whose WrDataOut returns the old word one cycle after WrAddr.
REQ-017 SHALL have ports RamRdEnb out 1, RamRdAddr out A, RamRdData in D: read port, data one cycle after address.

Function
REQ-018 FSM states SHALL be INIT, IDLE, FETCH, MERGE; reset enters INIT.
REQ-019 INIT SHALL write zero to addresses 0..2^A-1, one per cycle, via an A-bit counter; after address 2^A-1 it SHALL go to IDLE and set InitDone=1 the next cycle.
REQ-020 UpdReady SHALL be 0 outside IDLE; in IDLE UpdReady SHALL equal the grant: the sole valid requester, or on contention the round-robin pointer's requester.
REQ-021 The round-robin pointer SHALL flip to the other requester after every contended grant; after reset it SHALL favour requester 0.
REQ-022 On accept in cycle t: address/op/mask SHALL be captured; FETCH at t+1 drives RamWrAddr with RamWrEnb=0; MERGE at t+2 drives RamWrEnb=1, RamWrData = Op ? (RamWrDataOut|Mask) : (RamWrDataOut&~Mask); UpdDone[i] SHALL pulse at t+3; state returns to IDLE at t+3.
REQ-023 Update throughput SHALL be one per 3 cycles; updates are serialized, so no RMW hazard exists.
REQ-024 Lookups SHALL bypass the FSM: RamRdEnb=LkpValid&InitDone, RamRdAddr=LkpAddr; LkpRspValid SHALL be high at t+1 for a lookup at t; LkpRspData SHALL be valid only while LkpRspValid=1.
REQ-025 Lookups while InitDone=0 SHALL be dropped (no response).
REQ-026 Lookup and MERGE write to the same address in the same cycle: response SHALL follow REQ-034.

Reset
REQ-027 Asynchronous reset SHALL force: UpdReady=0, UpdDone=0, LkpRspValid=0, LkpRspData=0, InitDone=0, RamWrEnb=0, RamRdEnb=0, counter=0, pointer=0.
REQ-028 Reset during FETCH/MERGE SHALL abandon the update (no UpdDone) and restart the INIT sweep at address 0.

Configuration
REQ-029 Macro RAM_RMW_SCHED_BYPASS_EN SHALL select same-cycle write forwarding.
REQ-030 With it defined, a colliding lookup (REQ-026) SHALL return the merged (new) word.
REQ-031 Without it, a colliding lookup SHALL return RamRdData (old word, read-first).

Structure
REQ-032 A shared package SHALL hold the FSM state enum, op encoding (SET=1, CLR=0) and requester count constant (2).
REQ-033 A sub-module ram_rmw_rr_arb SHALL implement the 2-way round-robin grant.
REQ-034 Forwarding logic SHALL be a registered mux on LkpRspData, no extra latency.

Verification
REQ-035 After reset, sweep 512 cycles -> InitDone=1 at cycle 513; lookup of any address returns 0.
REQ-036 Req0 set addr 5 mask 0x0F, then req0 clear addr 5 mask 0x03 -> UpdDone[0] at t+3 each; lookup addr 5 returns 0x0C.
REQ-037 Both requesters valid continuously, distinct addresses -> grants alternate 0,1,0,1; each UpdDone every 6 cycles.
REQ-038 Lookup addr 7 in same cycle as MERGE set 0x80 on addr 7 (old 0) -> 0x80 with macro, 0x00 without.
REQ-039 Assert Rst_n=0 during MERGE -> no UpdDone, RamWrEnb low, INIT restarts at address 0.
